// File: rtl/apb_master_arb_if.sv
// Bundle of requester-side and APB-side signals for apb_master_arb.
//   master modport : the arbiter's view (drives APB control and completions)
//   slave modport  : the environment's view (drives requests, pready, prdata)
// Requester i owns bit i of req_valid/req_write/req_done/req_err and
// slice [i*AW +: AW] of req_addr, [i*DW +: DW] of req_wdata.
interface apb_master_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [1:0]      req_valid;
  logic [1:0]      req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      req_done;
  logic [1:0]      req_err;
  logic [DW-1:0]   rsp_rdata;
  logic            psel;
  logic            penable;
  logic            pwrite;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic            pready;
  logic [DW-1:0]   prdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, pready, prdata,
    output req_done, req_err, rsp_rdata, psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, pready, prdata,
    input  req_done, req_err, rsp_rdata, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master_arb.sv
// Two-requester round-robin APB master.
// A request seen in IDLE is granted, its fields are latched onto the APB
// address/data lines, and one SETUP plus one or more ACCESS cycles follow.
// The transfer ends on pready (normal completion) or after TIMEOUT ACCESS
// cycles with pready low (error completion); either way req_done pulses for
// the granted requester in the following IDLE cycle.
// Ports:
//   pclk    : clock, rising edge
//   presetn : asynchronous reset, active HIGH despite the name
//   bus     : apb_master_arb_if.master (requests, completions, APB signals)
// Parameters: AW/DW address/data width, TIMEOUT wait-cycle limit (0 = none).
// Every output is a flop, so nothing reaches the bus combinationally.
module apb_master_arb #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input logic              pclk,
  input logic              presetn,
  apb_master_arb_if.master bus
);

  // The counter only needs to reach TIMEOUT-1: that is the last ACCESS cycle
  // in which a low pready is still waited on.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t        state, state_d;
  logic          grant;     // requester owning the current transfer
  logic          last;      // requester granted most recently
  logic          win;       // arbitration result for this IDLE cycle
  logic [CW-1:0] wait_cnt;
  logic          start, finish, abort;

  // With both requesting, the one not served last wins; otherwise the only
  // requester wins (bit 1 alone selects requester 1).
  always_comb win = (bus.req_valid == 2'b11) ? ~last : bus.req_valid[1];

  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    start   = 1'b0;
    finish  = 1'b0;
    abort   = 1'b0;
    unique case (state)
      IDLE: begin
        if (|bus.req_valid) begin
          start   = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // pready wins over the timeout in the same cycle.
        if (bus.pready) begin
          finish  = 1'b1;
          state_d = IDLE;
        end else if (TIMEOUT > 0 && wait_cnt == WAIT_LAST) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge pclk or posedge presetn) begin
    if (presetn) state <= IDLE;
    else         state <= state_d;
  end

  always_ff @(posedge pclk or posedge presetn) begin
    if (presetn) begin
      grant         <= 1'b0;
      last          <= 1'b1;  // requester 0 wins the first tie
      wait_cnt      <= '0;
      bus.psel      <= 1'b0;
      bus.penable   <= 1'b0;
      bus.pwrite    <= 1'b0;
      bus.paddr     <= '0;
      bus.pwdata    <= '0;
      bus.rsp_rdata <= '0;
      bus.req_done  <= '0;
      bus.req_err   <= '0;
    end else begin
      // APB strobes track the state being entered, so they line up with it.
      bus.psel     <= (state_d != IDLE);
      bus.penable  <= (state_d == ACCESS);
      bus.req_done <= '0;
      bus.req_err  <= '0;

      if (start) begin
        grant      <= win;
        bus.pwrite <= bus.req_write[win];
        bus.paddr  <= win ? bus.req_addr[2*AW-1:AW] : bus.req_addr[AW-1:0];
        bus.pwdata <= win ? bus.req_wdata[2*DW-1:DW] : bus.req_wdata[DW-1:0];
        wait_cnt   <= '0;
      end

      if (state == ACCESS && !bus.pready) wait_cnt <= wait_cnt + 1'b1;

      if (finish || abort) begin
        bus.req_done <= grant ? 2'b10 : 2'b01;
        bus.req_err  <= abort ? (grant ? 2'b10 : 2'b01) : 2'b00;
        last         <= grant;
      end

      if (finish && !bus.pwrite) bus.rsp_rdata <= bus.prdata;
    end
  end

endmodule

// File: tb/tb_apb_master_arb.sv
// Self-checking bench for apb_master_arb (TIMEOUT = 4).
// Directed table of single transfers, hand-written reset and contention
// sequences, then randomized traffic checked cycle by cycle against a
// transaction-level timeline model.
module tb_apb_master_arb;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 4;
  localparam int N_RND   = 60;

  logic pclk    = 1'b0;
  logic presetn = 1'b1;
  always #5 pclk = ~pclk;

  apb_master_arb_if #(.AW(AW), .DW(DW)) bus ();

  apb_master_arb #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          id;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;      // ACCESS cycles with pready low before ready
    logic [31:0] prd;
    int          exp_access;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge pclk);
  endtask

  task automatic drive_idle();
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.pready    = 1'b0;
    bus.prdata    = '0;
  endtask

  task automatic drive_req(input int i, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    bus.req_valid[i]           = 1'b1;
    bus.req_write[i]           = wr;
    bus.req_addr[i*AW +: AW]   = a;
    bus.req_wdata[i*DW +: DW]  = d;
  endtask

  task automatic apply_reset();
    presetn = 1'b1;
    drive_idle();
    cyc();
    cyc();
    presetn = 1'b0;
  endtask

  // One transfer from an idle bus; ends at the negedge after the done cycle.
  task automatic run_vec(input vec_t v);
    logic [1:0] oh;
    int k;
    oh = (v.id == 1) ? 2'b10 : 2'b01;
    drive_req(v.id, v.wr, v.addr, v.wdata);
    cyc();
    check("setup_psel",    bus.psel, 1);
    check("setup_penable", bus.penable, 0);
    check("setup_paddr",   bus.paddr, v.addr);
    check("setup_pwrite",  bus.pwrite, v.wr);
    check("setup_pwdata",  bus.pwdata, v.wdata);
    check("setup_done",    bus.req_done, 0);
    bus.req_valid = '0;  // already latched; dropping valid must not cancel
    bus.pready    = 1'($urandom_range(0, 1));  // ignored during SETUP
    bus.prdata    = v.prd;
    k = 0;
    cyc();
    while (bus.psel && bus.penable && k < 20) begin
      check("access_paddr",  bus.paddr, v.addr);
      check("access_pwrite", bus.pwrite, v.wr);
      check("access_pwdata", bus.pwdata, v.wdata);
      bus.pready = (k == v.waits);
      k++;
      cyc();
    end
    check("access_cycles", k, v.exp_access);
    check("done_psel",     bus.psel, 0);
    check("done",          bus.req_done, oh);
    check("err",           bus.req_err, v.exp_err ? oh : 2'b00);
    check("rsp_rdata",     bus.rsp_rdata, v.exp_rdata);
    bus.pready = 1'b0;
    cyc();
    check("done_width", bus.req_done, 0);
    check("err_width",  bus.req_err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{id:0, wr:1'b1, addr:32'h5,   wdata:32'h6,    waits:0, prd:32'h0,
                exp_access:1, exp_err:1'b0, exp_rdata:32'h0};
    vecs[1] = '{id:1, wr:1'b0, addr:32'h5,   wdata:32'h11,   waits:2, prd:32'h6,
                exp_access:3, exp_err:1'b0, exp_rdata:32'h6};
    vecs[2] = '{id:0, wr:1'b1, addr:32'h100, wdata:32'hdead, waits:1, prd:32'h99,
                exp_access:2, exp_err:1'b0, exp_rdata:32'h6};
    vecs[3] = '{id:1, wr:1'b0, addr:32'h200, wdata:32'h0,    waits:9, prd:32'h77,
                exp_access:4, exp_err:1'b1, exp_rdata:32'h6};
    vecs[4] = '{id:0, wr:1'b0, addr:32'h300, wdata:32'h0,    waits:3, prd:32'hcafe,
                exp_access:4, exp_err:1'b0, exp_rdata:32'hcafe};
    vecs[5] = '{id:0, wr:1'b0, addr:32'h304, wdata:32'h0,    waits:4, prd:32'hbeef,
                exp_access:4, exp_err:1'b1, exp_rdata:32'hcafe};
    vecs[6] = '{id:1, wr:1'b1, addr:32'h40,  wdata:32'h1234, waits:0, prd:32'h0,
                exp_access:1, exp_err:1'b0, exp_rdata:32'h0};

    // Reset state
    presetn = 1'b1;
    drive_idle();
    cyc();
    check("rst_psel",    bus.psel, 0);
    check("rst_penable", bus.penable, 0);
    check("rst_pwrite",  bus.pwrite, 0);
    check("rst_paddr",   bus.paddr, 0);
    check("rst_pwdata",  bus.pwdata, 0);
    check("rst_rdata",   bus.rsp_rdata, 0);
    check("rst_done",    bus.req_done, 0);
    check("rst_err",     bus.req_err, 0);
    cyc();
    presetn = 1'b0;

    // Directed single transfers
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset in the middle of a waiting ACCESS
    drive_req(0, 1'b0, 32'h500, 32'h0);
    cyc();
    check("mid_rst_setup", bus.psel, 1);
    bus.req_valid = '0;
    bus.pready    = 1'b0;
    cyc();
    cyc();
    check("mid_rst_access", bus.penable, 1);
    #2 presetn = 1'b1;
    #1;
    check("async_rst_psel",    bus.psel, 0);
    check("async_rst_penable", bus.penable, 0);
    check("async_rst_done",    bus.req_done, 0);
    cyc();
    cyc();
    check("rst_hold_done",  bus.req_done, 0);
    check("rst_hold_rdata", bus.rsp_rdata, 0);
    presetn = 1'b0;
    run_vec(vecs[6]);

    // Contention from reset: both held valid, pready always high
    apply_reset();
    drive_req(0, 1'b1, 32'ha0, 32'h1);
    drive_req(1, 1'b1, 32'hb0, 32'h2);
    bus.pready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      int guard;
      logic [1:0] oh;
      guard = 0;
      oh = (n % 2 == 1) ? 2'b10 : 2'b01;
      cyc();
      while (!(bus.psel && !bus.penable) && guard < 10) begin
        guard++;
        cyc();
      end
      check("rr_grant_addr", bus.paddr, (n % 2 == 1) ? 32'hb0 : 32'ha0);
      check("rr_done_width", bus.req_done, 0);
      while (bus.req_done == 2'b00 && guard < 10) begin
        guard++;
        cyc();
      end
      check("rr_done", bus.req_done, oh);
      check("rr_err",  bus.req_err, 0);
    end
    drive_idle();

    // Randomized traffic against a transaction timeline model
    apply_reset();
    begin
      bit          busy, x_wr, x_err;
      int          t0, len, w, done_t, g, m_last, issued, completed;
      logic [31:0] x_addr, x_wdata, cap, m_rdata;
      bit          act[2];
      int          gap[2];
      logic        a_wr[2];
      logic [31:0] a_addr[2], a_wdata[2];
      busy = 0; m_last = 1; m_rdata = '0; cap = '0; issued = 0; completed = 0;
      t0 = 0; len = 0; w = 0; done_t = 0; g = 0; x_wr = 0; x_err = 0;
      x_addr = '0; x_wdata = '0;
      act = '{0, 0}; gap = '{0, 0};
      a_wr = '{0, 0}; a_addr = '{0, 0}; a_wdata = '{0, 0};
      for (int t = 0; t < 4000 && completed < N_RND; t++) begin
        bit in_sel, in_en;
        logic [1:0] e_done;
        // A transfer granted at t0 occupies SETUP at t0+1, ACCESS at
        // t0+2..t0+1+len, and reports completion at t0+2+len.
        in_sel = busy && t >= t0 + 1 && t <= t0 + 1 + len;
        in_en  = busy && t >= t0 + 2 && t <= t0 + 1 + len;
        e_done = 2'b00;
        if (busy && t == done_t) begin
          e_done = (g == 1) ? 2'b10 : 2'b01;
          if (!x_wr && !x_err) m_rdata = cap;
          m_last = g;
          busy   = 0;
          completed++;
        end
        check("rnd_psel",    bus.psel, in_sel);
        check("rnd_penable", bus.penable, in_en);
        check("rnd_done",    bus.req_done, e_done);
        check("rnd_err",     bus.req_err, x_err ? e_done : 2'b00);
        check("rnd_rdata",   bus.rsp_rdata, m_rdata);
        if (in_sel) begin
          check("rnd_paddr",  bus.paddr, x_addr);
          check("rnd_pwrite", bus.pwrite, x_wr);
          check("rnd_pwdata", bus.pwdata, x_wdata);
        end

        // Requesters: hold until done, then optionally re-request at once
        for (int i = 0; i < 2; i++) begin
          if (e_done[i]) begin
            act[i] = 0;
            gap[i] = $urandom_range(0, 2);
          end
          if (!act[i]) begin
            if (gap[i] > 0) gap[i]--;
            else if (issued < N_RND) begin
              act[i]     = 1;
              issued++;
              a_wr[i]    = 1'($urandom_range(0, 1));
              a_addr[i]  = $urandom;
              a_wdata[i] = $urandom;
            end
          end
          bus.req_valid[i]          = act[i];
          bus.req_write[i]          = a_wr[i];
          bus.req_addr[i*AW +: AW]  = act[i] ? a_addr[i] : $urandom;
          bus.req_wdata[i*DW +: DW] = act[i] ? a_wdata[i] : $urandom;
        end

        // Slave: ready after w low ACCESS cycles, random noise elsewhere
        if (in_en) begin
          int k;
          k = t - (t0 + 2);
          bus.pready = (k == w);
          bus.prdata = $urandom;
          if (k == w) cap = bus.prdata;
        end else begin
          bus.pready = 1'($urandom_range(0, 1));
          bus.prdata = $urandom;
        end

        // Arbitration happens in any cycle with no transfer in flight
        if (!busy && (act[0] || act[1])) begin
          g       = (act[0] && act[1]) ? 1 - m_last : (act[1] ? 1 : 0);
          busy    = 1;
          t0      = t;
          w       = $urandom_range(0, 5);
          x_err   = (w >= TIMEOUT);
          len     = x_err ? TIMEOUT : w + 1;
          done_t  = t0 + 2 + len;
          x_wr    = a_wr[g];
          x_addr  = a_addr[g];
          x_wdata = a_wdata[g];
        end
        cyc();
      end
      check("rnd_completed", completed, N_RND);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
